// File: rtl/cim_xbar_tile.sv
// Compute-in-memory crossbar tile: 1-bit weight array times an activation vector,
// one output column per cycle, results saturated into a readable output buffer.
module cim_xbar_tile #(
  parameter  int xbar_size     = 512,
  parameter  int datatype_size = 8,
  localparam int aw            = (xbar_size > 1) ? $clog2(xbar_size) : 1,
  localparam int acc_size      = datatype_size + aw
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_we,
  input  logic [aw-1:0]            i_wr_addr,
  input  logic [datatype_size-1:0] i_wr_data,
  input  logic                     i_w_we,
  input  logic [aw-1:0]            i_w_row,
  input  logic [aw-1:0]            i_w_col,
  input  logic                     i_w_bit,
  input  logic                     i_start,
  output logic                     o_busy,
  output logic                     o_done,
  input  logic [aw-1:0]            i_rd_addr,
  output logic [datatype_size-1:0] o_rd_data
);

  typedef enum logic [1:0] {S_IDLE, S_COMPUTE, S_DONE} state_t;

  localparam logic [aw-1:0]       last_col = aw'(xbar_size - 1);
  localparam logic [acc_size-1:0] max_val  = {{(acc_size-datatype_size){1'b0}}, {datatype_size{1'b1}}};

  state_t                   state_q;
  logic [aw-1:0]            col_q;
  logic                     busy_q;
  logic                     done_q;
  logic [datatype_size-1:0] rd_data_q;

  logic [xbar_size-1:0]     w_q    [xbar_size];
  logic [datatype_size-1:0] in_q   [xbar_size];
  logic [datatype_size-1:0] obuf_q [xbar_size];

  logic [acc_size-1:0]      col_sum;
  logic [datatype_size-1:0] col_sat;

  function automatic logic in_range(input logic [aw-1:0] a);
    return int'(a) < xbar_size;
  endfunction

  always_comb begin
    col_sum = '0;
    for (int r = 0; r < xbar_size; r++) begin
      if (w_q[r][col_q]) col_sum = col_sum + acc_size'(in_q[r]);
    end
    col_sat = (col_sum > max_val) ? {datatype_size{1'b1}} : col_sum[datatype_size-1:0];
  end

  // Operand storage is frozen while busy so a running multiply sees a stable matrix and vector.
  always_ff @(posedge clk) begin
    if (!rst && !busy_q) begin
      if (i_we && in_range(i_wr_addr)) in_q[i_wr_addr] <= i_wr_data;
      if (i_w_we && in_range(i_w_row) && in_range(i_w_col)) w_q[i_w_row][i_w_col] <= i_w_bit;
    end
    if (!rst && state_q == S_COMPUTE) obuf_q[col_q] <= col_sat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= in_range(i_rd_addr) ? obuf_q[i_rd_addr] : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      col_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            state_q <= S_COMPUTE;
            busy_q  <= 1'b1;
            col_q   <= '0;
          end
        end
        S_COMPUTE: begin
          if (col_q == last_col) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            col_q   <= '0;
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_rd_data = rd_data_q;

endmodule
